// File: rtl/riscv_load_pkg.sv
// Load encodings, the load FSM state type and size helpers shared by the load unit.
// Pure declarations: no latency, no backpressure.
// Funct3 legality depends on XLEN, so the helper takes it as an argument.
package riscv_load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } load_state_t;

  function automatic logic [3:0] access_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return 4'd1;
      F3_LH, F3_LHU: return 4'd2;
      F3_LW, F3_LWU: return 4'd4;
      default:       return 4'd8;
    endcase
  endfunction

  // 111 never decodes; LD/LWU only exist when registers are 64 bits wide.
  function automatic logic f3_legal(input logic [2:0] f3, input int xlen);
    if (f3 == 3'b111) return 1'b0;
    if ((xlen == 32) && ((f3 == F3_LD) || (f3 == F3_LWU))) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed bytes from a two-word window and sign/zero-extends them.
// Combinational, zero latency; no backpressure.
// The offset port is always 3 bits; 32-bit users tie its MSB to zero.
module load_extract
  import riscv_load_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] pair,
  input  logic [2:0]        offset,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   result
);

  logic [XLEN-1:0] win;

  assign win = XLEN'(pair >> {offset, 3'b000});

  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = XLEN'($signed(win[7:0]));
      F3_LH:   result = XLEN'($signed(win[15:0]));
      F3_LW:   result = XLEN'($signed(win[31:0]));
      F3_LBU:  result = XLEN'(win[7:0]);
      F3_LHU:  result = XLEN'(win[15:0]);
      F3_LWU:  result = XLEN'(win[31:0]);
      F3_LD:   result = win;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/misaligned_load_unit.sv
// Load unit that issues one or two aligned memory beats and returns the extended result.
// Latency: result 1 cycle after the last memory response; faults answer 1 cycle after request.
// Backpressure: one load in flight, req_ready only in IDLE; result held until rsp_ready.
module misaligned_load_unit
  import riscv_load_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_fault
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  load_state_t     state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] beat0_q, beat0_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            fault_q, fault_d;
  logic            issued_q, issued_d;

  logic [3:0]        req_size, cur_size, req_off4;
  logic [4:0]        span;
  logic              crosses, req_fault;
  logic [XLEN-1:0]   aligned_addr;
  logic [2*XLEN-1:0] pair;
  logic [XLEN-1:0]   extracted;

  assign req_size = access_size(req_funct3);
  assign req_off4 = 4'(req_addr[OW-1:0]);
  assign req_fault = !f3_legal(req_funct3, XLEN) ||
                     (!MISALIGN_EN && ((req_off4 & (req_size - 4'd1)) != 4'd0));

  assign cur_size     = access_size(funct3_q);
  assign span         = 5'(addr_q[OW-1:0]) + 5'(cur_size);
  assign crosses      = span > 5'(NB);
  assign aligned_addr = {addr_q[XLEN-1:OW], {OW{1'b0}}};

  // Beat 1 always holds the upper bytes; a single-beat load pads the top with zeros.
  assign pair = (state_q == BEAT1) ? {mem_rsp_data, beat0_q} : {{XLEN{1'b0}}, mem_rsp_data};

  load_extract #(.XLEN(XLEN)) u_extract (
    .pair   (pair),
    .offset (3'(addr_q[OW-1:0])),
    .funct3 (funct3_q),
    .result (extracted)
  );

  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign rsp_data      = data_q;
  assign rsp_fault     = fault_q;
  assign mem_req_valid = ((state_q == BEAT0) || (state_q == BEAT1)) && !issued_q;
  assign mem_req_addr  = (state_q == BEAT1) ? aligned_addr + XLEN'(NB) : aligned_addr;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    beat0_d  = beat0_q;
    data_d   = data_q;
    fault_d  = fault_q;
    issued_d = issued_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          issued_d = 1'b0;
          if (req_fault) begin
            state_d = RESP;
            fault_d = 1'b1;
            data_d  = '0;
          end else begin
            state_d = BEAT0;
            fault_d = 1'b0;
          end
        end
      end
      BEAT0: begin
        issued_d = 1'b1;
        if (mem_rsp_valid) begin
          if (crosses) begin
            state_d  = BEAT1;
            beat0_d  = mem_rsp_data;
            issued_d = 1'b0;
          end else begin
            state_d = RESP;
            data_d  = extracted;
          end
        end
      end
      BEAT1: begin
        issued_d = 1'b1;
        if (mem_rsp_valid) begin
          state_d = RESP;
          data_d  = extracted;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      beat0_q  <= '0;
      data_q   <= '0;
      fault_q  <= 1'b0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      beat0_q  <= beat0_d;
      data_q   <= data_d;
      fault_q  <= fault_d;
      issued_q <= issued_d;
    end
  end

endmodule

// File: tb/tb_misaligned_load_unit.sv
// Bench for misaligned_load_unit: three instances (32-bit split, 64-bit split, 32-bit faulting)
// exercised with directed and random loads against a byte-level reference model.
module tb_misaligned_load_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid     [3];
  logic [63:0] req_addr      [3];
  logic [2:0]  req_funct3    [3];
  logic        mem_rsp_valid [3];
  logic [63:0] mem_rsp_data  [3];
  logic        rsp_ready     [3];

  logic        o_req_ready [3];
  logic        o_mreq_vld  [3];
  logic [63:0] o_mreq_addr [3];
  logic        o_rsp_vld   [3];
  logic [63:0] o_rsp_data  [3];
  logic        o_rsp_fault [3];

  logic        rr0, mv0, rv0, rf0, rr1, mv1, rv1, rf1, rr2, mv2, rv2, rf2;
  logic [31:0] ma0, rd0, ma2, rd2;
  logic [63:0] ma1, rd1;

  int checks = 0;
  int errors = 0;

  misaligned_load_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(rr0),
    .req_addr(req_addr[0][31:0]), .req_funct3(req_funct3[0]),
    .mem_req_valid(mv0), .mem_req_addr(ma0), .mem_rsp_valid(mem_rsp_valid[0]),
    .mem_rsp_data(mem_rsp_data[0][31:0]), .rsp_valid(rv0), .rsp_ready(rsp_ready[0]),
    .rsp_data(rd0), .rsp_fault(rf0));

  misaligned_load_unit #(.XLEN(64), .MISALIGN_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(rr1),
    .req_addr(req_addr[1]), .req_funct3(req_funct3[1]),
    .mem_req_valid(mv1), .mem_req_addr(ma1), .mem_rsp_valid(mem_rsp_valid[1]),
    .mem_rsp_data(mem_rsp_data[1]), .rsp_valid(rv1), .rsp_ready(rsp_ready[1]),
    .rsp_data(rd1), .rsp_fault(rf1));

  misaligned_load_unit #(.XLEN(32), .MISALIGN_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(rr2),
    .req_addr(req_addr[2][31:0]), .req_funct3(req_funct3[2]),
    .mem_req_valid(mv2), .mem_req_addr(ma2), .mem_rsp_valid(mem_rsp_valid[2]),
    .mem_rsp_data(mem_rsp_data[2][31:0]), .rsp_valid(rv2), .rsp_ready(rsp_ready[2]),
    .rsp_data(rd2), .rsp_fault(rf2));

  always_comb begin
    o_req_ready[0] = rr0; o_mreq_vld[0] = mv0; o_mreq_addr[0] = {32'b0, ma0};
    o_rsp_vld[0]   = rv0; o_rsp_data[0] = {32'b0, rd0}; o_rsp_fault[0] = rf0;
    o_req_ready[1] = rr1; o_mreq_vld[1] = mv1; o_mreq_addr[1] = ma1;
    o_rsp_vld[1]   = rv1; o_rsp_data[1] = rd1; o_rsp_fault[1] = rf1;
    o_req_ready[2] = rr2; o_mreq_vld[2] = mv2; o_mreq_addr[2] = {32'b0, ma2};
    o_rsp_vld[2]   = rv2; o_rsp_data[2] = {32'b0, rd2}; o_rsp_fault[2] = rf2;
  end

  // Reference: gather bytes from the little-endian two-word window, then extend.
  function automatic void model(input int xlen, input bit men, input logic [63:0] addr_in,
                                input logic [2:0] f3, input logic [63:0] w0, input logic [63:0] w1,
                                output logic [63:0] data, output bit fault, output int beats,
                                output logic [63:0] a0, output logic [63:0] a1);
    int nb, size, off;
    logic [63:0] addr, mask;
    logic [7:0] bytes [16];
    nb   = xlen / 8;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    addr = addr_in & mask;
    size = 1 << f3[1:0];
    off  = int'(addr % 64'(nb));
    a0   = addr - 64'(off);
    a1   = (a0 + 64'(nb)) & mask;
    fault = (f3 == 3'd7) || (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6)) ||
            (!men && (off % size) != 0);
    data  = 64'h0;
    beats = 0;
    if (!fault) begin
      for (int i = 0; i < 16; i++) bytes[i] = (i < nb) ? w0[8*i +: 8] : w1[8*(i-nb) +: 8];
      for (int i = 0; i < size; i++) data[8*i +: 8] = bytes[off + i];
      if (f3[2] == 1'b0 && size < 8 && data[8*size-1])
        for (int i = 8*size; i < 64; i++) data[i] = 1'b1;
      data  = data & mask;
      beats = (off + size > nb) ? 2 : 1;
    end
  endfunction

  task automatic do_load(input int d, input logic [63:0] addr, input logic [2:0] f3,
                         input logic [63:0] w0, input logic [63:0] w1, input int lat,
                         input int hold, input string tag,
                         output logic [63:0] got_data, output logic got_fault);
    int xlen, exp_beats, beats, cnt, last_rsp, c;
    bit men, exp_fault, got;
    logic [63:0] exp_data, ea0, ea1;
    logic [63:0] ba [4];
    xlen = (d == 1) ? 64 : 32;
    men  = (d != 2);
    model(xlen, men, addr, f3, w0, w1, exp_data, exp_fault, exp_beats, ea0, ea1);
    checks++;
    if (o_req_ready[d] !== 1'b1) begin
      errors++; $display("FAIL %s req_ready_idle got %b want 1", tag, o_req_ready[d]);
    end
    req_valid[d] = 1'b1; req_addr[d] = addr; req_funct3[d] = f3;
    @(posedge clk); @(negedge clk);
    req_valid[d] = 1'b0;
    beats = 0; cnt = -1; last_rsp = -1; got = 1'b0; c = 0;
    got_data = '0; got_fault = 1'b0;
    while (c < 60 && !got) begin
      mem_rsp_valid[d] = 1'b0;
      if (o_rsp_vld[d] === 1'b1) begin
        got = 1'b1; got_data = o_rsp_data[d]; got_fault = o_rsp_fault[d];
      end else begin
        if (o_mreq_vld[d] === 1'b1) begin
          if (beats < 4) ba[beats] = o_mreq_addr[d];
          beats++; cnt = lat;
        end
        if (cnt == 0) begin
          mem_rsp_valid[d] = 1'b1;
          mem_rsp_data[d]  = (beats <= 1) ? w0 : w1;
          last_rsp = c; cnt = -1;
        end else if (cnt > 0) cnt--;
        @(posedge clk); @(negedge clk);
        c++;
      end
    end
    mem_rsp_valid[d] = 1'b0;
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s rsp_timeout got none want rsp_valid", tag);
    end else begin
      checks += 4;
      if (got_fault !== exp_fault) begin
        errors++; $display("FAIL %s fault got %b want %b", tag, got_fault, exp_fault);
      end
      if (got_data !== exp_data) begin
        errors++; $display("FAIL %s data got %h want %h", tag, got_data, exp_data);
      end
      if (beats != exp_beats) begin
        errors++; $display("FAIL %s beats got %0d want %0d", tag, beats, exp_beats);
      end
      if ((exp_beats == 0 && c != 0) || (exp_beats > 0 && c - last_rsp != 1)) begin
        errors++; $display("FAIL %s latency got c=%0d last_rsp=%0d want 1", tag, c, last_rsp);
      end
      if (exp_beats >= 1 && beats >= 1) begin
        checks++;
        if (ba[0] !== ea0) begin
          errors++; $display("FAIL %s beat0_addr got %h want %h", tag, ba[0], ea0);
        end
      end
      if (exp_beats == 2 && beats >= 2) begin
        checks++;
        if (ba[1] !== ea1) begin
          errors++; $display("FAIL %s beat1_addr got %h want %h", tag, ba[1], ea1);
        end
      end
      for (int h = 0; h < hold; h++) begin
        mem_rsp_valid[d] = 1'b1;
        mem_rsp_data[d]  = {$urandom, $urandom};
        @(posedge clk); @(negedge clk);
        mem_rsp_valid[d] = 1'b0;
        checks++;
        if (o_rsp_vld[d] !== 1'b1 || o_rsp_data[d] !== got_data || o_req_ready[d] !== 1'b0) begin
          errors++;
          $display("FAIL %s hold_stable got vld=%b data=%h rdy=%b want vld=1 data=%h rdy=0",
                   tag, o_rsp_vld[d], o_rsp_data[d], o_req_ready[d], got_data);
        end
      end
      rsp_ready[d] = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp_ready[d] = 1'b0;
      checks++;
      if (o_rsp_vld[d] !== 1'b0 || o_req_ready[d] !== 1'b1) begin
        errors++; $display("FAIL %s release got vld=%b rdy=%b want vld=0 rdy=1",
                           tag, o_rsp_vld[d], o_req_ready[d]);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (o_req_ready[d] !== 1'b1 || o_mreq_vld[d] !== 1'b0 || o_rsp_vld[d] !== 1'b0 ||
          o_rsp_fault[d] !== 1'b0 || o_rsp_data[d] !== 64'h0) begin
        errors++;
        $display("FAIL %s dut%0d got rdy=%b mreq=%b vld=%b fault=%b data=%h want 1 0 0 0 0",
                 tag, d, o_req_ready[d], o_mreq_vld[d], o_rsp_vld[d], o_rsp_fault[d], o_rsp_data[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 0; req_addr[d] = '0; req_funct3[d] = '0;
      mem_rsp_valid[d] = 0; mem_rsp_data[d] = '0; rsp_ready[d] = 0;
    end
    #3;
    check_idle("reset_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_directed();
    logic [63:0] dat; logic flt;
    do_load(0, 64'h3, 3'b000, 64'h80FF_FFFF, 64'h0, 0, 0, "lb_addr3", dat, flt);
    checks++;
    if (dat !== 64'hFFFF_FF80) begin
      errors++; $display("FAIL lb_addr3_const got %h want ffffff80", dat);
    end
    do_load(0, 64'h3, 3'b101, 64'hAB00_0000, 64'h0000_00CD, 1, 0, "lhu_split", dat, flt);
    checks++;
    if (dat !== 64'h0000_CDAB) begin
      errors++; $display("FAIL lhu_split_const got %h want 0000cdab", dat);
    end
    do_load(1, 64'h6, 3'b010, 64'h89AB_0000_0000_0000, 64'hDEAD_BEEF_CAFE_4567, 0, 0,
            "lw64_split", dat, flt);
    checks++;
    if (dat !== 64'h0000_0000_4567_89AB) begin
      errors++; $display("FAIL lw64_split_const got %h want 00000000456789ab", dat);
    end
    do_load(2, 64'h2, 3'b010, 64'h1234_5678, 64'h0, 0, 0, "lw_nomisalign", dat, flt);
    checks++;
    if (flt !== 1'b1 || dat !== 64'h0) begin
      errors++; $display("FAIL lw_nomisalign_const got fault=%b data=%h want 1 0", flt, dat);
    end
    do_load(0, 64'hFFFF_FFFE, 3'b010, 64'h5566_7788, 64'h1122_3344, 2, 0, "lw_wrap32", dat, flt);
    do_load(1, 64'hFFFF_FFFF_FFFF_FFFD, 3'b011, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0,
            "ld_wrap64", dat, flt);
    do_load(0, 64'h0, 3'b011, 64'h1, 64'h0, 0, 0, "ld_illegal32", dat, flt);
    do_load(1, 64'h8, 3'b111, 64'h1, 64'h0, 0, 0, "f3_111", dat, flt);
  endtask

  task automatic test_backpressure();
    logic [63:0] dat; logic flt;
    do_load(1, 64'h1005, 3'b011, 64'hA1B2_C3D4_E5F6_0718, 64'h2938_4756_6574_8392, 1, 5,
            "bp_ld64", dat, flt);
    do_load(0, 64'h0000_0104, 3'b001, 64'h0000_8001, 64'h0, 0, 5, "bp_lh32", dat, flt);
  endtask

  task automatic test_ignore_idle_rsp();
    logic [63:0] dat; logic flt;
    for (int d = 0; d < 3; d++) begin
      mem_rsp_valid[d] = 1'b1; mem_rsp_data[d] = 64'hFFFF_FFFF_FFFF_FFFF;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      mem_rsp_valid[d] = 1'b0;
      checks++;
      if (o_rsp_vld[d] !== 1'b0 || o_req_ready[d] !== 1'b1 || o_mreq_vld[d] !== 1'b0) begin
        errors++; $display("FAIL idle_rsp dut%0d got vld=%b rdy=%b mreq=%b want 0 1 0",
                           d, o_rsp_vld[d], o_req_ready[d], o_mreq_vld[d]);
      end
    end
    do_load(0, 64'h9, 3'b100, 64'h0000_7F00, 64'h0, 0, 0, "after_idle_rsp", dat, flt);
  endtask

  task automatic test_random();
    logic [63:0] dat; logic flt;
    for (int n = 0; n < 150; n++) begin
      do_load($urandom_range(0, 2), {$urandom, $urandom}, 3'($urandom_range(0, 7)),
              {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3),
              $urandom_range(0, 2), $sformatf("rand%0d", n), dat, flt);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    req_valid[0] = 1'b1; req_addr[0] = 64'h3; req_funct3[0] = 3'b101;
    @(posedge clk); @(negedge clk);
    req_valid[0] = 1'b0;
    mem_rsp_valid[0] = 1'b1; mem_rsp_data[0] = 64'hAB00_0000;
    @(posedge clk); @(negedge clk);
    mem_rsp_valid[0] = 1'b0;
    c = 0;
    while (o_mreq_vld[0] !== 1'b1 && c < 10) begin
      @(posedge clk); @(negedge clk); c++;
    end
    checks++;
    if (o_mreq_vld[0] !== 1'b1 || o_mreq_addr[0] !== 64'h4) begin
      errors++; $display("FAIL mid_beat1 got mreq=%b addr=%h want 1 4", o_mreq_vld[0], o_mreq_addr[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    check_idle("reset_mid_async");
    mem_rsp_valid[0] = 1'b1; mem_rsp_data[0] = 64'h0000_00CD;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (o_rsp_vld[0] !== 1'b0 || o_mreq_vld[0] !== 1'b0 || o_req_ready[0] !== 1'b1) begin
        errors++; $display("FAIL reset_mid_stale got vld=%b mreq=%b rdy=%b want 0 0 1",
                           o_rsp_vld[0], o_mreq_vld[0], o_req_ready[0]);
      end
    end
    mem_rsp_valid[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_idle_rsp();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
